// File: rtl/xrv_pkg.sv
// -----------------------------------------------------------------------------
// xrv_pkg -- shared types for the instruction fetch slice.
//   ifq_entry_t   : one instruction-queue entry (fetch PC + instruction word)
//   fetch_state_e : fetch bus state machine (IDLE, REQ, DISCARD)
//   PC_STEP       : byte distance between consecutive instruction words
//   word_align()  : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package xrv_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Masking (rather than slicing) keeps every address bit referenced.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo -- synchronous instruction queue, first-word-fall-through read.
// Parameters:
//   DEPTH : number of entries, power of two, minimum 2
// Ports:
//   clk   in   rising-edge clock
//   rstb  in   synchronous active-low reset (empties the queue)
//   flush in   discard all entries at the next edge (wins over push/pop)
//   push  in   write din at the next edge
//   din   in   entry to write
//   pop   in   drop the head entry at the next edge
//   dout  out  head entry (undefined while empty)
//   full  out  DEPTH entries held
//   empty out  no entries held
//   count out  number of entries held
// A push into a full queue is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module ifq_fifo
  import xrv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     flush,
  input  logic                     push,
  input  ifq_entry_t               din,
  input  logic                     pop,
  output ifq_entry_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop, wr_en;
  ifq_entry_t    mem_q [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_en   = do_push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch -- instruction fetch unit: issues word reads on the instruction bus,
// buffers responses in an instruction queue and offers them to decode.
// Parameters:
//   RESET_PC  : address of the first fetch after reset
//   IFQ_DEPTH : instruction queue entries (power of two, minimum 2)
// Ports:
//   clk        in   rising-edge clock
//   rstb       in   synchronous active-low reset
//   i_addr     out  instruction bus word address (bits [1:0] always 0)
//   i_rd_req   out  read request, held with i_addr until i_rd_ready
//   i_rd_ready in   read complete, i_rd_data valid this cycle
//   i_rd_data  in   instruction word
//   jmp        in   redirect from execute
//   jmp_addr   in   redirect target
//   if_valid   out  instruction offered to decode
//   if_ready   in   decode accepts the offered instruction
//   if_pc      out  PC of the offered instruction
//   if_instr   out  offered instruction word
// Build option:
//   IFETCH_BYPASS_EN : when defined, a response arriving while the queue is
//   empty is offered to decode in the same cycle (and only queued if decode
//   does not take it). Otherwise responses become visible one cycle later.
// -----------------------------------------------------------------------------
module ifetch
  import xrv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IFQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstb,
  output logic [31:0] i_addr,
  output logic        i_rd_req,
  input  logic        i_rd_ready,
  input  logic [31:0] i_rd_data,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(IFQ_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   i_addr_q, i_addr_d;
  logic          i_rd_req_q, i_rd_req_d;

  logic          rsp_accept, bypass_hit, space;
  logic          q_push, q_pop, q_full, q_empty;
  logic [CW-1:0] q_count, occ_next;
  ifq_entry_t    q_din, q_dout;

  // A response is kept only in REQ and only if no redirect arrives with it.
  assign rsp_accept = (state_q == REQ) & i_rd_ready & ~jmp;
  assign q_din      = '{pc: i_addr_q, instr: i_rd_data};

`ifdef IFETCH_BYPASS_EN
  assign bypass_hit = rsp_accept & q_empty;
  assign if_valid   = (~q_empty | bypass_hit) & ~jmp;
  assign if_pc      = bypass_hit ? i_addr_q  : q_dout.pc;
  assign if_instr   = bypass_hit ? i_rd_data : q_dout.instr;
`else
  assign bypass_hit = 1'b0;
  assign if_valid   = ~q_empty & ~jmp;
  assign if_pc      = q_dout.pc;
  assign if_instr   = q_dout.instr;
`endif

  // A bypassed word taken by decode never enters the queue.
  assign q_push = rsp_accept & ~(bypass_hit & if_ready) & (~q_full | q_pop);
  assign q_pop  = if_valid & if_ready & ~q_empty;

  // Occupancy after this edge; a pop this cycle frees room for a request
  // next cycle, which is what keeps delivery gap-free after backpressure.
  assign occ_next = q_count + CW'(q_push) - CW'(q_pop);
  assign space    = (occ_next < CW'(IFQ_DEPTH));

  ifq_fifo #(
    .DEPTH (IFQ_DEPTH)
  ) u_ifq (
    .clk   (clk),
    .rstb  (rstb),
    .flush (jmp),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    if (jmp)             fetch_pc_d = word_align(jmp_addr);
    else if (rsp_accept) fetch_pc_d = fetch_pc_q + PC_STEP;

    unique case (state_q)
      IDLE: begin
        if (jmp || space) state_d = REQ;
      end
      REQ: begin
        if (jmp)             state_d = i_rd_ready ? REQ : DISCARD;
        else if (i_rd_ready) state_d = space ? REQ : IDLE;
      end
      DISCARD: begin
        if (i_rd_ready) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // The stale request stays on the bus while its response is awaited.
    i_addr_d   = (state_d == DISCARD) ? i_addr_q : fetch_pc_d;
    i_rd_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      i_addr_q   <= word_align(RESET_PC);
      i_rd_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      i_addr_q   <= i_addr_d;
      i_rd_req_q <= i_rd_req_d;
    end
  end

  assign i_addr   = i_addr_q;
  assign i_rd_req = i_rd_req_q;

endmodule
